// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling, a single-entry
// valid/ready holding register, and framing-error / overrun pulses.
module uart_rx #(
  parameter int DIV = 54  // CLK cycles per oversample tick (1/16 bit)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       sin_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_rxs;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_smp;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;

  logic        w_tick;
  logic        w_mid;
  logic        w_wrap;
  logic        w_shift_en;
  logic        w_stop_good;
  logic        w_stop_bad;
  logic        w_xfer;

  // Two-flop synchroniser on the asynchronous line; idles high.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= sin_in;
      r_rxs   <= r_sync1;
    end
  end

  // Oversample tick only runs while a frame is being tracked.
  assign w_tick = (r_state != S_IDLE) && (r_div_cnt == DIV_LAST);
  assign w_mid  = w_tick && (r_smp == 4'd7);
  assign w_wrap = w_tick && (r_smp == 4'd15);
  assign w_xfer = rx_valid && rx_ready;
  assign busy   = (r_state != S_IDLE);

  // Next-state decode and per-cycle strobes for the datapath.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    w_next      = r_state;
    w_shift_en  = 1'b0;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxs) w_next = S_START;
      end
      S_START: begin
        // Mid start bit: a high line here was only a glitch.
        if (w_mid) w_next = r_rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_wrap) begin
          w_shift_en = 1'b1;
          if (r_bitcnt == 3'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave half a bit early so a back-to-back start edge is not missed.
        if (w_wrap) begin
          w_stop_good = r_rxs;
          w_stop_bad  = !r_rxs;
          w_next      = r_rxs ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must release before a new frame can start.
        if (r_rxs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Tick divider, tick counter and bit counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_div_cnt <= '0;
      r_smp     <= '0;
      r_bitcnt  <= '0;
    end else begin
      // Held at zero in IDLE, so leaving IDLE always starts a fresh divide.
      if (r_state == S_IDLE || w_tick) r_div_cnt <= '0;
      else                             r_div_cnt <= r_div_cnt + 16'd1;

      if (w_next != r_state) begin
        r_smp    <= '0;
        r_bitcnt <= '0;
      end else begin
        if (w_tick)     r_smp    <= r_smp + 4'd1;
        if (w_shift_en) r_bitcnt <= r_bitcnt + 3'd1;
      end
    end
  end

  // Shift register, holding register and status pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shift   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_stop_bad;
      overrun   <= 1'b0;
      if (w_shift_en) r_shift <= {r_rxs, r_shift[7:1]};  // LSB first
      if (w_stop_good) begin
        // A consumer taking the old byte this cycle frees the slot.
        if (!rx_valid || w_xfer) begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (w_xfer) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end for the UART link between the host and the processor on the Nexys4 DDR board. It is the receiving end of the 8N1 serial stream, meaning the host-to-board direction that enters on the `sin_in` pin. The block synchronises the pin, oversamples it 16x, and recovers framed bytes. It hands each byte to the core through a single-entry valid/ready holding register and flags framing errors and overruns.

## Interface
- `DIV`, default 54: CLK cycles per oversample tick (1/16 bit). 54 gives 115200 baud at 100 MHz. Legal range is 2..65535.
- `CLK`  in  1  system clock; every register changes on its rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `sin_in`  in  1  asynchronous serial line; idle level 1.
- `rx_data`  out  8  received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts; a transfer happens when `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `overrun`  out  1  one-cycle pulse: a byte completed while the holding register was full and not being consumed.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Synchroniser**
  - Two flops on `sin_in`, both reset to 1.
  - All logic uses the second flop (`rxs`).
- **Tick generator**
  - `div_cnt` counts 0..DIV-1 and asserts `tick` when `div_cnt`=DIV-1.
  - It clears on every transition out of IDLE.
  - `smp` is a 4-bit tick counter, cleared on every state change.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE**
  - `rxs`=0 → START.
- **START**
  - On the tick that makes `smp`=7 (mid start bit), sample `rxs`.
  - `rxs`=1 → IDLE (false start).
  - `rxs`=0 → DATA, with `smp` and `bitcnt` cleared.
- **DATA**
  - On every tick that makes `smp` wrap 15→0, shift `rxs` into a shift register, LSB first.
  - After the 8th bit → STOP.
- **STOP**
  - On the 16th tick, sample `rxs`.
  - `rxs`=1 → deliver the byte, then IDLE.
  - `rxs`=0 → pulse `frame_err`, discard the byte, then WAIT_HIGH.
- **WAIT_HIGH**
  - Stay until `rxs`=1, then IDLE.
  - A held-low line (break) therefore produces exactly one `frame_err`.
- **Deliver**
  - If `rx_valid`=0, or a transfer happens in the same cycle: load `rx_data` and set `rx_valid`.
  - Otherwise: drop the new byte, pulse `overrun`, and leave `rx_data` unchanged.
- **Holding register**
  - Transfer without a simultaneous deliver → clear `rx_valid`.
  - `rx_valid` never drops without a transfer.
- **Reset, including mid-frame**
  - State → IDLE; all counters → 0.
  - `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - The synchroniser flops → 1.
  - A frame in progress is abandoned.

## Timing
- Pin to `rxs` latency is 2 CLK.
- The start bit is sampled 8·DIV CLK after the falling edge reaches `rxs`, within ±1 CLK.
- Data bit n (n=0..7) is sampled 8·DIV + 16·DIV·(n+1) CLK after that edge.
- The stop bit is sampled at 8·DIV + 144·DIV CLK.
- `rx_valid`, `frame_err` and `overrun` rise 1 CLK after the stop-bit sample.
- `frame_err` and `overrun` are exactly 1 CLK wide.
- Back-to-back frames:
  - IDLE is re-entered right after the stop-bit sample, half a bit before the frame ends, so a next start edge is caught without loss.
  - Minimum spacing is 1 stop bit.
- Sampling tolerates a baud mismatch of ±4% between sender and receiver.
- `rx_ready` may be held high continuously; throughput is one byte per frame.

## Test plan
Benches run with `DIV`=4, so one bit is 64 CLK.
- Reset for 3 cycles, then send 0xA5 as 8N1 with `rx_ready`=1 → `rx_valid` pulses for 1 CLK with `rx_data`=0xA5, with no `frame_err` or `overrun`; then `busy`=0.
- Drive `sin_in` low for 20 CLK, then high → no `rx_valid`; `busy` returns to 0 within 40 CLK of the falling edge.
- Send 0x3C with the stop bit forced to 0 for 64 CLK, then idle, then send 0x3C correctly → one `frame_err` pulse and no delivery; the second frame delivers 0x3C.
- Hold `rx_ready`=0 and send 0x11 then 0x22 back-to-back → after frame 1, `rx_valid`=1 with `rx_data`=0x11; after frame 2, one `overrun` pulse and `rx_data` still 0x11. Raising `rx_ready` for 1 CLK → `rx_valid`=0.
- With `rx_ready`=0, send 0x55, then assert `rx_ready` in exactly the cycle the next byte 0xAA delivers → no `overrun`; `rx_data`=0xAA and `rx_valid` stays 1.
- Assert `RST` during data bit 3 of a frame → next cycle all outputs are at reset values. A fresh 0x7E frame after reset is received correctly, and the truncated frame yields nothing.
